// File: rtl/hmac_ctrl_pkg.sv
// rtl/hmac_ctrl_pkg.sv - shared constants, register map and FSM state type for the HMAC register front-end
package hmac_ctrl_pkg;

  localparam int ADDR_NAME0     = 'h00;
  localparam int ADDR_NAME1     = 'h04;
  localparam int ADDR_VERSION0  = 'h08;
  localparam int ADDR_VERSION1  = 'h0C;
  localparam int ADDR_CTRL      = 'h10;
  localparam int ADDR_STATUS    = 'h18;
  localparam int ADDR_INTR      = 'h1C;
  localparam int ADDR_KEY_BASE  = 'h40;
  localparam int ADDR_BLOCK_BASE = 'h80;
  localparam int ADDR_TAG_BASE  = 'h100;

  localparam int CTRL_INIT    = 0;
  localparam int CTRL_NEXT    = 1;
  localparam int CTRL_ZEROIZE = 2;
  localparam int CTRL_MODE    = 3;

  localparam int STATUS_READY = 0;
  localparam int STATUS_VALID = 1;

  localparam int INTR_DONE = 0;
  localparam int INTR_ERR  = 1;

  // Key and tag words beyond this index are unused by HMAC-384
  localparam int WORDS_384 = 12;

  localparam logic [31:0] NAME0    = 32'h686d6163;
  localparam logic [31:0] NAME1    = 32'h2d353132;
  localparam logic [31:0] VERSION0 = 32'h312e3030;
  localparam logic [31:0] VERSION1 = 32'h00000000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} hmac_ctrl_state_e;

endpackage

// File: rtl/hmac_ctrl_regs_if.sv
// rtl/hmac_ctrl_regs_if.sv - 32-bit register bus between host and the HMAC register front-end
interface hmac_ctrl_regs_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  cs;
  logic                  we;
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           write_data;
  logic [31:0]           read_data;

  modport master (output cs, we, address, write_data, input read_data);
  modport slave  (input cs, we, address, write_data, output read_data);
endinterface

// File: rtl/hmac_ctrl_fsm.sv
// rtl/hmac_ctrl_fsm.sv - issue/ack/done sequencer: command acceptance, core pulses, err/done events
module hmac_ctrl_fsm
  import hmac_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic ctrl_wr,
  input  logic init_bit,
  input  logic next_bit,
  input  logic zeroize_bit,
  input  logic kb_wr,
  input  logic core_ready,
  input  logic core_tag_valid,
  output logic idle,
  output logic core_init,
  output logic core_next,
  output logic core_zeroize,
  output logic accept_init,
  output logic accept_start,
  output logic zero_now,
  output logic capture,
  output logic set_err
);

  hmac_ctrl_state_e state_q, state_d;
  logic op_init_q, op_init_d;
  logic init_done_q, init_done_d;
  logic zero_q, valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_init_q   <= 1'b0;
      init_done_q <= 1'b0;
      zero_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_init_q   <= op_init_d;
      init_done_q <= init_done_d;
      zero_q      <= zero_now;
      valid_q     <= core_tag_valid;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_init_d    = op_init_q;
    init_done_d  = init_done_q;
    accept_init  = 1'b0;
    accept_start = 1'b0;
    capture      = 1'b0;
    set_err      = 1'b0;
    zero_now     = ctrl_wr && zeroize_bit;
    case (state_q)
      IDLE: begin
        if (ctrl_wr && !zeroize_bit) begin
          if (init_bit) begin
            accept_init  = 1'b1;
            accept_start = 1'b1;
            op_init_d    = 1'b1;
            state_d      = ISSUE;
          end else if (next_bit) begin
            if (init_done_q) begin
              accept_start = 1'b1;
              op_init_d    = 1'b0;
              state_d      = ISSUE;
            end else begin
              set_err = 1'b1;
            end
          end
        end
      end
      ISSUE:     state_d = WAIT_ACK;
      WAIT_ACK:  if (!core_ready) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (core_tag_valid && !valid_q) begin
          capture     = 1'b1;
          init_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
    if (state_q != IDLE && ctrl_wr && !zeroize_bit && (init_bit || next_bit)) set_err = 1'b1;
    if (state_q != IDLE && kb_wr) set_err = 1'b1;
    // Zeroize overrides everything, including a completion in the same cycle
    if (zero_now) begin
      state_d     = IDLE;
      init_done_d = 1'b0;
      capture     = 1'b0;
    end
  end

  assign idle         = (state_q == IDLE);
  assign core_init    = (state_q == ISSUE) && op_init_q;
  assign core_next    = (state_q == ISSUE) && !op_init_q;
  assign core_zeroize = zero_q;

endmodule

// File: rtl/hmac_ctrl_regs.sv
// rtl/hmac_ctrl_regs.sv - register file, read mux and core-facing datapath of the HMAC-384/512 front-end
module hmac_ctrl_regs
  import hmac_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int KEY_WORDS   = 16,
  parameter int BLOCK_WORDS = 32,
  parameter int TAG_WORDS   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  hmac_ctrl_regs_if.slave          bus,
  output logic                     core_init,
  output logic                     core_next,
  output logic                     core_mode,
  output logic                     core_zeroize,
  output logic [32*KEY_WORDS-1:0]  core_key,
  output logic [32*BLOCK_WORDS-1:0] core_block,
  input  logic                     core_ready,
  input  logic [32*TAG_WORDS-1:0]  core_tag,
  input  logic                     core_tag_valid,
  output logic                     intr
);

  localparam int KIW = $clog2(KEY_WORDS);
  localparam int BIW = $clog2(BLOCK_WORDS);
  localparam int TIW = $clog2(TAG_WORDS);

  logic [31:0] key_q   [KEY_WORDS];
  logic [31:0] block_q [BLOCK_WORDS];
  logic [31:0] tag_q   [TAG_WORDS];
  logic        tag_valid_q, mode_q;
  logic [1:0]  intr_q;

  logic [ADDR_WIDTH-1:0] key_off, block_off, tag_off;
  logic key_hit, block_hit, tag_hit, wr, ctrl_wr, intr_wr;
  logic idle, accept_init, accept_start, zero_now, capture, set_err;
  logic [31:0] rdata;

  assign key_off   = bus.address - ADDR_WIDTH'(ADDR_KEY_BASE);
  assign block_off = bus.address - ADDR_WIDTH'(ADDR_BLOCK_BASE);
  assign tag_off   = bus.address - ADDR_WIDTH'(ADDR_TAG_BASE);
  assign key_hit   = (key_off   < ADDR_WIDTH'(4*KEY_WORDS))   && (key_off[1:0]   == 2'b00);
  assign block_hit = (block_off < ADDR_WIDTH'(4*BLOCK_WORDS)) && (block_off[1:0] == 2'b00);
  assign tag_hit   = (tag_off   < ADDR_WIDTH'(4*TAG_WORDS))   && (tag_off[1:0]   == 2'b00);

  assign wr      = bus.cs && bus.we;
  assign ctrl_wr = wr && (bus.address == ADDR_WIDTH'(ADDR_CTRL));
  assign intr_wr = wr && (bus.address == ADDR_WIDTH'(ADDR_INTR));

  hmac_ctrl_fsm u_fsm (
    .clk            (clk),
    .reset_n        (reset_n),
    .ctrl_wr        (ctrl_wr),
    .init_bit       (bus.write_data[CTRL_INIT]),
    .next_bit       (bus.write_data[CTRL_NEXT]),
    .zeroize_bit    (bus.write_data[CTRL_ZEROIZE]),
    .kb_wr          (wr && (key_hit || block_hit)),
    .core_ready     (core_ready),
    .core_tag_valid (core_tag_valid),
    .idle           (idle),
    .core_init      (core_init),
    .core_next      (core_next),
    .core_zeroize   (core_zeroize),
    .accept_init    (accept_init),
    .accept_start   (accept_start),
    .zero_now       (zero_now),
    .capture        (capture),
    .set_err        (set_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < KEY_WORDS; i++)   key_q[i]   <= '0;
      for (int i = 0; i < BLOCK_WORDS; i++) block_q[i] <= '0;
      for (int i = 0; i < TAG_WORDS; i++)   tag_q[i]   <= '0;
      tag_valid_q <= 1'b0;
      mode_q      <= 1'b0;
      intr_q      <= 2'b00;
    end else begin
      if (zero_now) begin
        for (int i = 0; i < KEY_WORDS; i++)   key_q[i]   <= '0;
        for (int i = 0; i < BLOCK_WORDS; i++) block_q[i] <= '0;
        for (int i = 0; i < TAG_WORDS; i++)   tag_q[i]   <= '0;
        tag_valid_q <= 1'b0;
        mode_q      <= 1'b0;
      end else begin
        if (idle && wr && key_hit)   key_q[key_off[2 +: KIW]]     <= bus.write_data;
        if (idle && wr && block_hit) block_q[block_off[2 +: BIW]] <= bus.write_data;
        if (accept_init) mode_q <= bus.write_data[CTRL_MODE];
        if (accept_start) begin
          for (int i = 0; i < TAG_WORDS; i++) tag_q[i] <= '0;
          tag_valid_q <= 1'b0;
        end
        if (capture) begin
          for (int i = 0; i < TAG_WORDS; i++)
            tag_q[i] <= (mode_q || i < WORDS_384) ? core_tag[32*(TAG_WORDS-1-i) +: 32] : 32'h0;
          tag_valid_q <= 1'b1;
        end
      end
      // New events win over a same-cycle write-1-to-clear
      intr_q <= (intr_q & ~(intr_wr ? bus.write_data[1:0] : 2'b00)) | {set_err, capture};
    end
  end

  for (genvar i = 0; i < KEY_WORDS; i++) begin : g_key
    assign core_key[32*(KEY_WORDS-1-i) +: 32] = (mode_q || i < WORDS_384) ? key_q[i] : 32'h0;
  end
  for (genvar i = 0; i < BLOCK_WORDS; i++) begin : g_block
    assign core_block[32*(BLOCK_WORDS-1-i) +: 32] = block_q[i];
  end

  assign core_mode = mode_q;
  assign intr      = |intr_q;

  always_comb begin
    rdata = 32'h0;
    if (bus.cs && !bus.we) begin
      if (key_hit)        rdata = key_q[key_off[2 +: KIW]];
      else if (block_hit) rdata = block_q[block_off[2 +: BIW]];
      else if (tag_hit)   rdata = tag_q[tag_off[2 +: TIW]];
      else begin
        case (bus.address)
          ADDR_WIDTH'(ADDR_NAME0):    rdata = NAME0;
          ADDR_WIDTH'(ADDR_NAME1):    rdata = NAME1;
          ADDR_WIDTH'(ADDR_VERSION0): rdata = VERSION0;
          ADDR_WIDTH'(ADDR_VERSION1): rdata = VERSION1;
          ADDR_WIDTH'(ADDR_CTRL):     rdata = {28'h0, mode_q, 3'b000};
          ADDR_WIDTH'(ADDR_STATUS):   rdata = {30'h0, tag_valid_q, idle && core_ready};
          ADDR_WIDTH'(ADDR_INTR):     rdata = {30'h0, intr_q};
          default:                    rdata = 32'h0;
        endcase
      end
    end
  end

  assign bus.read_data = rdata;

endmodule

// File: tb/tb_hmac_ctrl_regs.sv
// tb/tb_hmac_ctrl_regs.sv - directed self-checking bench for hmac_ctrl_regs
module tb_hmac_ctrl_regs;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         core_init, core_next, core_mode, core_zeroize, intr;
  logic [511:0] core_key;
  logic [1023:0] core_block;
  logic         core_ready = 1'b1;
  logic [511:0] core_tag = '0;
  logic         core_tag_valid = 1'b0;
  int           compared = 0;
  int           mismatched = 0;
  logic [31:0]  rd;

  hmac_ctrl_regs_if #(.ADDR_WIDTH(32)) bus ();

  hmac_ctrl_regs dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus.slave),
    .core_init      (core_init),
    .core_next      (core_next),
    .core_mode      (core_mode),
    .core_zeroize   (core_zeroize),
    .core_key       (core_key),
    .core_block     (core_block),
    .core_ready     (core_ready),
    .core_tag       (core_tag),
    .core_tag_valid (core_tag_valid),
    .intr           (intr)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1; bus.address = a; bus.write_data = d;
    @(posedge clk);
    #1 bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b0; bus.address = a;
    #1 d = bus.read_data;
    bus.cs = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic core_ack();
    repeat (2) @(posedge clk);
    @(negedge clk) core_ready = 1'b0;
  endtask

  task automatic core_done(input int wait_cycles, input logic [31:0] w);
    repeat (wait_cycles) @(posedge clk);
    @(negedge clk);
    core_tag = {16{w}}; core_tag_valid = 1'b1;
    @(negedge clk);
    core_tag_valid = 1'b0; core_ready = 1'b1;
  endtask

  task automatic test_reset();
    compared++; if (core_init !== 1'b0 || core_next !== 1'b0 || core_zeroize !== 1'b0) begin mismatched++; $display("FAIL reset_pulses got %b%b%b want 000", core_init, core_next, core_zeroize); end
    compared++; if (core_key !== '0 || core_block !== '0 || core_mode !== 1'b0 || intr !== 1'b0) begin mismatched++; $display("FAIL reset_outputs got key/block/mode/intr nonzero"); end
    bus_read(32'h18, rd);
    compared++; if (rd !== 32'h1) begin mismatched++; $display("FAIL reset_status got %h want 00000001", rd); end
    bus_read(32'h00, rd);
    compared++; if (rd !== 32'h686d6163) begin mismatched++; $display("FAIL name0 got %h want 686d6163", rd); end
    bus_read(32'h08, rd);
    compared++; if (rd !== 32'h312e3030) begin mismatched++; $display("FAIL version0 got %h want 312e3030", rd); end
    bus_read(32'h14, rd);
    compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL unmapped got %h want 0", rd); end
    bus_read(32'h1000_0000, rd);
    compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL alias got %h want 0", rd); end
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1; bus.address = 32'h0; bus.write_data = 32'h0;
    #1 rd = bus.read_data;
    bus.cs = 1'b0; bus.we = 1'b0;
    compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL read_during_write got %h want 0", rd); end
  endtask

  task automatic test_init_384();
    for (int i = 0; i < 12; i++) bus_write(32'h40 + 4*i, 32'h0B0B0B0B);
    bus_write(32'h80, 32'h61626380);
    bus_write(32'h80 + 4*31, 32'h00000400);
    bus_write(32'h10, 32'h1);
    compared++; if (core_init !== 1'b1 || core_next !== 1'b0) begin mismatched++; $display("FAIL init_pulse got init=%b next=%b want 1 0", core_init, core_next); end
    compared++; if (core_mode !== 1'b0) begin mismatched++; $display("FAIL init_mode got %b want 0", core_mode); end
    compared++; if (core_key[511:128] !== {12{32'h0B0B0B0B}}) begin mismatched++; $display("FAIL key_words got %h", core_key[511:128]); end
    compared++; if (core_key[127:0] !== 128'h0) begin mismatched++; $display("FAIL key_upper got %h want 0", core_key[127:0]); end
    compared++; if (core_block[1023:992] !== 32'h61626380 || core_block[31:0] !== 32'h400) begin mismatched++; $display("FAIL block got %h %h", core_block[1023:992], core_block[31:0]); end
    @(posedge clk); #1;
    compared++; if (core_init !== 1'b0) begin mismatched++; $display("FAIL init_one_cycle got %b want 0", core_init); end
  endtask

  task automatic test_done_384();
    core_ack();
    core_done(40, 32'hA5A5A5A5);
    bus_read(32'h18, rd);
    compared++; if (rd !== 32'h3) begin mismatched++; $display("FAIL done_status got %h want 00000003", rd); end
    for (int i = 0; i < 16; i++) begin
      bus_read(32'h100 + 4*i, rd);
      compared++; if (rd !== ((i < 12) ? 32'hA5A5A5A5 : 32'h0)) begin mismatched++; $display("FAIL tag%0d got %h", i, rd); end
    end
    compared++; if (intr !== 1'b1) begin mismatched++; $display("FAIL done_intr got %b want 1", intr); end
  endtask

  task automatic test_busy_lockout();
    bus_write(32'h1C, 32'h3);
    bus_write(32'h10, 32'h9);
    compared++; if (core_init !== 1'b1 || core_mode !== 1'b1) begin mismatched++; $display("FAIL init512 got init=%b mode=%b want 1 1", core_init, core_mode); end
    bus_read(32'h10, rd);
    compared++; if (rd !== 32'h8) begin mismatched++; $display("FAIL ctrl_read got %h want 00000008", rd); end
    core_ack();
    bus_write(32'h80 + 4*5, 32'hDEADBEEF);
    bus_read(32'h80 + 4*5, rd);
    compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL block5_locked got %h want 0", rd); end
    bus_read(32'h1C, rd);
    compared++; if (rd !== 32'h2) begin mismatched++; $display("FAIL busy_err got %h want 00000002", rd); end
    core_done(5, 32'h5A5A5A5A);
    bus_read(32'h1C, rd);
    compared++; if (rd !== 32'h3) begin mismatched++; $display("FAIL intr_after_done got %h want 00000003", rd); end
    bus_read(32'h100 + 4*15, rd);
    compared++; if (rd !== 32'h5A5A5A5A) begin mismatched++; $display("FAIL tag15_512 got %h want 5a5a5a5a", rd); end
    bus_write(32'h1C, 32'h3);
    compared++; if (intr !== 1'b0) begin mismatched++; $display("FAIL intr_w1c got %b want 0", intr); end
  endtask

  task automatic test_next_rules();
    apply_reset();
    bus_write(32'h10, 32'h2);
    compared++; if (core_next !== 1'b0 || core_init !== 1'b0) begin mismatched++; $display("FAIL orphan_next got next=%b init=%b want 0 0", core_next, core_init); end
    bus_read(32'h1C, rd);
    compared++; if (rd !== 32'h2) begin mismatched++; $display("FAIL orphan_next_err got %h want 00000002", rd); end
    bus_write(32'h1C, 32'h2);
    bus_write(32'h10, 32'h3);
    compared++; if (core_init !== 1'b1 || core_next !== 1'b0) begin mismatched++; $display("FAIL init_wins got init=%b next=%b want 1 0", core_init, core_next); end
    bus_read(32'h1C, rd);
    compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL init_wins_err got %h want 0", rd); end
    core_ack();
    core_done(3, 32'h11111111);
    bus_write(32'h10, 32'hA);
    compared++; if (core_next !== 1'b1 || core_init !== 1'b0 || core_mode !== 1'b0) begin mismatched++; $display("FAIL next_after_init got next=%b init=%b mode=%b want 1 0 0", core_next, core_init, core_mode); end
    core_ack();
    core_done(3, 32'h22222222);
    bus_write(32'h1C, 32'h3);
  endtask

  task automatic test_zeroize();
    bus_write(32'h40, 32'h12345678);
    bus_write(32'h80, 32'h9ABCDEF0);
    bus_write(32'h10, 32'h9);
    core_ack();
    bus_write(32'h10, 32'h4);
    compared++; if (core_zeroize !== 1'b1) begin mismatched++; $display("FAIL zeroize_pulse got %b want 1", core_zeroize); end
    @(posedge clk); #1;
    compared++; if (core_zeroize !== 1'b0) begin mismatched++; $display("FAIL zeroize_one_cycle got %b want 0", core_zeroize); end
    bus_read(32'h40, rd);
    compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL zeroize_key got %h want 0", rd); end
    bus_read(32'h80, rd);
    compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL zeroize_block got %h want 0", rd); end
    bus_read(32'h10, rd);
    compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL zeroize_mode got %h want 0", rd); end
    core_done(3, 32'h77777777);
    bus_read(32'h18, rd);
    compared++; if (rd !== 32'h1) begin mismatched++; $display("FAIL zeroize_idle got %h want 00000001", rd); end
    bus_read(32'h100, rd);
    compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL zeroize_tag got %h want 0", rd); end
    compared++; if (intr !== 1'b0) begin mismatched++; $display("FAIL zeroize_intr got %b want 0", intr); end
    bus_write(32'h10, 32'h2);
    compared++; if (core_next !== 1'b0) begin mismatched++; $display("FAIL next_after_zeroize got %b want 0", core_next); end
    bus_read(32'h1C, rd);
    compared++; if (rd !== 32'h2) begin mismatched++; $display("FAIL next_after_zeroize_err got %h want 00000002", rd); end
  endtask

  task automatic test_reset_mid_op();
    bus_write(32'h40, 32'hCAFEF00D);
    bus_write(32'h10, 32'h9);
    compared++; if (core_init !== 1'b1 || intr !== 1'b1) begin mismatched++; $display("FAIL pre_reset got init=%b intr=%b want 1 1", core_init, intr); end
    reset_n = 1'b0;
    #1;
    compared++; if (core_init !== 1'b0 || core_next !== 1'b0 || core_zeroize !== 1'b0 || core_mode !== 1'b0 || intr !== 1'b0) begin mismatched++; $display("FAIL mid_reset_ctrl got %b%b%b%b%b want 00000", core_init, core_next, core_zeroize, core_mode, intr); end
    compared++; if (core_key !== '0 || core_block !== '0) begin mismatched++; $display("FAIL mid_reset_data got nonzero key/block"); end
    @(negedge clk) reset_n = 1'b1;
    core_ready = 1'b1;
    bus_read(32'h18, rd);
    compared++; if (rd !== 32'h1) begin mismatched++; $display("FAIL post_reset_status got %h want 00000001", rd); end
  endtask

  initial begin
    bus.cs = 1'b0; bus.we = 1'b0; bus.address = '0; bus.write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk) reset_n = 1'b1;
    test_init_384();
    test_done_384();
    test_busy_lockout();
    test_next_rules();
    test_zeroize();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
